// File: rtl/midi_msg_parser_pkg.sv
// rtl/midi_msg_parser_pkg.sv - MIDI status constants and parser state encoding
package midi_msg_parser_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PBEND    = 4'hE;
  localparam logic [3:0] SYS_NIB  = 4'hF;

  localparam logic [7:0] SYS_EX     = 8'hF0;
  localparam logic [7:0] SYS_MTC    = 8'hF1;
  localparam logic [7:0] SYS_SPP    = 8'hF2;
  localparam logic [7:0] SYS_SONG   = 8'hF3;
  localparam logic [7:0] SYS_TUNE   = 8'hF6;
  localparam logic [7:0] SYS_RT_MIN = 8'hF8;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SYSEX     = 2'd3
  } state_t;

endpackage

// File: rtl/midi_len_lut.sv
// rtl/midi_len_lut.sv - status byte to data length, voice and real-time flags
module midi_len_lut
  import midi_msg_parser_pkg::*;
(
  input  logic [7:0] status,
  output logic [1:0] len,
  output logic       is_voice,
  output logic       is_rt
);

  always_comb begin
    len      = 2'd0;
    is_voice = status[7] && (status[7:4] != SYS_NIB);
    is_rt    = (status >= SYS_RT_MIN);
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PBEND: len = 2'd2;
      PROG, CHAN_AT:                           len = 2'd1;
      SYS_NIB: begin
        if (status == SYS_SPP)
          len = 2'd2;
        else if (status == SYS_MTC || status == SYS_SONG)
          len = 2'd1;
      end
      default: len = 2'd0;
    endcase
  end

endmodule

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - frames MIDI bytes into messages with running status
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter logic       OMNI      = 1'b1,
  parameter logic [3:0] CHANNEL   = 4'd0,
  parameter logic       NOTE0_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       overflow
);

  state_t     state_q, state_n;
  logic [7:0] status_q, status_n;
  logic [1:0] len_q, len_n;
  logic       voice_q, voice_n;
  logic [6:0] d1_q, d1_n;

  logic [1:0] in_len;
  logic       in_voice, in_rt;

  logic       emit, emit_ok;
  logic [7:0] emit_status;
  logic [6:0] emit_d1, emit_d2;

  midi_len_lut u_len_lut (
    .status   (byte_in),
    .len      (in_len),
    .is_voice (in_voice),
    .is_rt    (in_rt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NO_STATUS;
      status_q <= 8'd0;
      len_q    <= 2'd0;
      voice_q  <= 1'b0;
      d1_q     <= 7'd0;
    end else begin
      state_q  <= state_n;
      status_q <= status_n;
      len_q    <= len_n;
      voice_q  <= voice_n;
      d1_q     <= d1_n;
    end
  end

  // Real-time bytes bypass this block entirely so framing state is untouched.
  always_comb begin
    state_n     = state_q;
    status_n    = status_q;
    len_n       = len_q;
    voice_n     = voice_q;
    d1_n        = d1_q;
    emit        = 1'b0;
    emit_status = status_q;
    emit_d1     = 7'd0;
    emit_d2     = 7'd0;
    if (byte_valid && !in_rt) begin
      if (byte_in[7]) begin
        if (byte_in == SYS_EX) begin
          status_n = 8'd0;
          len_n    = 2'd0;
          voice_n  = 1'b0;
          state_n  = SYSEX;
        end else if (in_len != 2'd0) begin
          status_n = byte_in;
          len_n    = in_len;
          voice_n  = in_voice;
          state_n  = WAIT_D1;
        end else begin
          status_n = 8'd0;
          len_n    = 2'd0;
          voice_n  = 1'b0;
          state_n  = NO_STATUS;
          if (byte_in == SYS_TUNE) begin
            emit        = 1'b1;
            emit_status = SYS_TUNE;
          end
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_n = byte_in[6:0];
            if (len_q == 2'd1) begin
              emit    = 1'b1;
              emit_d1 = byte_in[6:0];
            end else begin
              state_n = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_q;
            emit_d2 = byte_in[6:0];
          end
          default: ;
        endcase
        // Voice status persists as running status; system status is one-shot.
        if (emit) begin
          if (voice_q) begin
            state_n = WAIT_D1;
          end else begin
            state_n  = NO_STATUS;
            status_n = 8'd0;
            len_n    = 2'd0;
          end
        end
      end
    end
    if (NOTE0_OFF && emit_status[7:4] == NOTE_ON && emit_d2 == 7'd0)
      emit_status = {NOTE_OFF, emit_status[3:0]};
  end

  assign emit_ok = emit && ((emit_status[7:4] == SYS_NIB) || OMNI ||
                            (emit_status[3:0] == CHANNEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_valid  <= 1'b0;
      msg_status <= 8'd0;
      msg_data1  <= 7'd0;
      msg_data2  <= 7'd0;
      rt_valid   <= 1'b0;
      rt_byte    <= 8'd0;
      overflow   <= 1'b0;
    end else begin
      rt_valid <= byte_valid && in_rt;
      if (byte_valid && in_rt)
        rt_byte <= byte_in;
      overflow <= emit_ok && msg_valid && !msg_ready;
      if (emit_ok && (!msg_valid || msg_ready)) begin
        msg_valid  <= 1'b1;
        msg_status <= emit_status;
        msg_data1  <= emit_d1;
        msg_data2  <= emit_d2;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - scoreboard bench for midi_msg_parser (omni and channel-2 instances)
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       msg_ready = 1'b0;

  logic       a_msg_valid, a_rt_valid, a_overflow;
  logic [7:0] a_msg_status, a_rt_byte;
  logic [6:0] a_msg_data1, a_msg_data2;
  logic       b_msg_valid, b_rt_valid, b_overflow;
  logic [7:0] b_msg_status, b_rt_byte;
  logic [6:0] b_msg_data1, b_msg_data2;

  always #5 clk = ~clk;

  midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0), .NOTE0_OFF(1'b1)) dut_a (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
    .msg_valid(a_msg_valid), .msg_ready(msg_ready), .msg_status(a_msg_status),
    .msg_data1(a_msg_data1), .msg_data2(a_msg_data2), .rt_valid(a_rt_valid),
    .rt_byte(a_rt_byte), .overflow(a_overflow)
  );

  midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd2), .NOTE0_OFF(1'b1)) dut_b (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
    .msg_valid(b_msg_valid), .msg_ready(msg_ready), .msg_status(b_msg_status),
    .msg_data1(b_msg_data1), .msg_data2(b_msg_data2), .rt_valid(b_rt_valid),
    .rt_byte(b_rt_byte), .overflow(b_overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: message-level framer plus per-instance output slot.
  logic [7:0]  cur = 8'd0;
  logic [6:0]  dbuf[$];
  logic [21:0] q0[$];
  logic [21:0] q1[$];
  bit          mv[2], mv_now[2], ovf_p[2], ovf_now[2];
  bit          rt_p, rt_now, clr_p, seen_rst, mon_en;
  logic [7:0]  rtb_p = 8'd0, rtb_now = 8'd0;
  logic        rdy = 1'b1;

  function automatic int dlen(input logic [7:0] s);
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2;
      4'hC, 4'hD: return 1;
      4'hF: return (s == 8'hF2) ? 2 : ((s == 8'hF1 || s == 8'hF3) ? 1 : 0);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d actual=%0h required=%0h @%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic step(input logic bv, input logic [7:0] b, input logic r);
    bit         have, keep;
    logic [7:0] st;
    logic [6:0] d1, d2;
    have = 0; st = 8'd0; d1 = 7'd0; d2 = 7'd0;
    rt_p = bv && (b >= 8'hF8);
    if (rt_p) rtb_p = b;
    if (bv && b < 8'hF8) begin
      if (b[7]) begin
        dbuf.delete();
        if ((b >= 8'h80 && b <= 8'hEF) || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) begin
          cur = b;
        end else begin
          cur = 8'd0;
          if (b == 8'hF6) begin have = 1; st = 8'hF6; end
        end
      end else if (cur != 8'd0) begin
        dbuf.push_back(b[6:0]);
        if (dbuf.size() == dlen(cur)) begin
          have = 1; st = cur; d1 = dbuf[0];
          d2 = (dlen(cur) == 2) ? dbuf[1] : 7'd0;
          dbuf.delete();
          if (cur >= 8'hF0) cur = 8'd0;
        end
      end
    end
    if (have && st[7:4] == 4'h9 && d2 == 7'd0) st = {4'h8, st[3:0]};
    for (int i = 0; i < 2; i++) begin
      keep = (st[7:4] == 4'hF) || (i == 0) || (st[3:0] == 4'd2);
      ovf_p[i] = 0;
      if (have && keep) begin
        if (!mv[i] || r) begin
          if (i == 0) q0.push_back({st, d1, d2}); else q1.push_back({st, d1, d2});
          mv[i] = 1;
        end else begin
          ovf_p[i] = 1;
        end
      end else if (mv[i] && r) begin
        mv[i] = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic bv, input logic [7:0] b);
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      mv_now[i]  = mv[i];
      ovf_now[i] = ovf_p[i];
    end
    rt_now  = rt_p;
    rtb_now = rtb_p;
    if (clr_p) begin q0.delete(); q1.delete(); clr_p = 0; end
    if (seen_rst) mon_en = 1;
    rst = r; byte_valid = bv; byte_in = b;
    msg_ready = r ? 1'b0 : rdy;
    if (r) begin
      cur = 8'd0; dbuf.delete(); rt_p = 0; clr_p = 1; seen_rst = 1;
      for (int i = 0; i < 2; i++) begin mv[i] = 0; ovf_p[i] = 0; end
    end else begin
      step(bv, b, msg_ready);
    end
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b1, b);
    cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_inst(input int i, input logic v, input logic [7:0] st,
                            input logic [6:0] a, input logic [6:0] c, input logic ov);
    int sz;
    chk("msg_valid", i, {31'd0, v}, {31'd0, mv_now[i]});
    chk("overflow", i, {31'd0, ov}, {31'd0, ovf_now[i]});
    if (v && mv_now[i]) begin
      sz = (i == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        vectors++; miscompares++;
        $display("FAIL msg_unexpected inst%0d actual=%0h required=none", i, {st, a, c});
      end else begin
        chk("msg", i, {10'd0, st, a, c}, {10'd0, (i == 0) ? q0[0] : q1[0]});
        if (msg_ready) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_inst(0, a_msg_valid, a_msg_status, a_msg_data1, a_msg_data2, a_overflow);
      check_inst(1, b_msg_valid, b_msg_status, b_msg_data1, b_msg_data2, b_overflow);
      chk("rt_valid", 0, {31'd0, a_rt_valid}, {31'd0, rt_now});
      chk("rt_valid", 1, {31'd0, b_rt_valid}, {31'd0, rt_now});
      if (rt_now) begin
        chk("rt_byte", 0, {24'd0, a_rt_byte}, {24'd0, rtb_now});
        chk("rt_byte", 1, {24'd0, b_rt_byte}, {24'd0, rtb_now});
      end
    end
  end

  task automatic check_zero();
    @(negedge clk);
    chk("rst_status", 0, {24'd0, a_msg_status}, 32'd0);
    chk("rst_data1", 0, {25'd0, a_msg_data1}, 32'd0);
    chk("rst_data2", 0, {25'd0, a_msg_data2}, 32'd0);
    chk("rst_rt_byte", 0, {24'd0, a_rt_byte}, 32'd0);
    chk("rst_valid", 1, {31'd0, b_msg_valid}, 32'd0);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    check_zero();

    rdy = 1'b1;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h3E); send(8'h50);
    send(8'h91); send(8'h40); send(8'h00);
    send(8'hC2); send(8'h05);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    send(8'hF0); send(8'h7E); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h40);
    send(8'hF2); send(8'h10); send(8'h20); send(8'h30);
    send(8'hF6); send(8'hF3); send(8'h05);

    rdy = 1'b0;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h90); send(8'h3D); send(8'h64);
    send(8'h3E);
    rdy = 1'b1;
    send(8'h64);
    cycle(1'b0, 1'b0, 8'd0);

    send(8'h91); send(8'h3C); send(8'h64);
    send(8'h92); send(8'h3C); send(8'h64);

    send(8'h90); send(8'h3C);
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    check_zero();
    send(8'h64);

    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(0, 99);
      if (k < 45)      b = {1'b0, 7'($urandom_range(0, 127))};
      else if (k < 70) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
      else if (k < 78) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (k < 83) b = 8'hF0;
      else if (k < 87) b = 8'hF7;
      else if (k < 97) b = 8'($urandom_range(8'hF1, 8'hF6));
      else             b = 8'h00;
      rdy = ($urandom_range(0, 3) != 0);
      if (k >= 97) cycle(1'b1, 1'b0, 8'd0);
      else         cycle(1'b0, 1'b1, b);
      for (int g = 0; g < 1 + int'($urandom_range(0, 1)); g++) begin
        rdy = ($urandom_range(0, 3) != 0);
        cycle(1'b0, 1'b0, 8'd0);
      end
    end

    rdy = 1'b1;
    for (int g = 0; g < 4; g++) cycle(1'b0, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    chk("q_drained", 0, q0.size(), 32'd0);
    chk("q_drained", 1, q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
